// File: rtl/limn2600_pkg.sv
// Shared types and helpers for the Limn2600 memory controller: access sizes,
// controller states, grant encoding and lane helpers.
package limn2600_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_WR_ISSUE,
      ST_WR_WAIT,
      ST_RMW_RD_ISSUE,
      ST_RMW_RD_WAIT,
      ST_RMW_WR_ISSUE,
      ST_RMW_WR_WAIT,
      ST_DONE
   } memctl_state_e;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_e;

   // Size code 3 is reserved and never counts as aligned.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: return 1'b1;
         SIZE_HALF: return ~addr_lo[0];
         SIZE_WORD: return (addr_lo == 2'b00);
         default:   return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] size_mask(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 32'h0000_00FF;
         SIZE_HALF: return 32'h0000_FFFF;
         default:   return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/limn2600_lane_merge.sv
// Little-endian lane handling: pulls a right-justified sub-word out of a
// memory word and merges store data into the addressed lanes of a word.
module limn2600_lane_merge
   import limn2600_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   output logic [31:0] extract_data,
   output logic [31:0] insert_data
);

   logic [4:0]  shift;
   logic [31:0] mask;

   assign shift        = {addr_lo, 3'b000};
   assign mask         = size_mask(size);
   assign extract_data = (word >> shift) & mask;
   assign insert_data  = (word & ~(mask << shift)) | ((wdata & mask) << shift);

endmodule

// File: rtl/limn2600_memctl.sv
// Arbitrates fetch and load/store requests onto the single-ported SRAM,
// turning sub-word stores into read-modify-write and flagging errors.
module limn2600_memctl
   import limn2600_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdy
);

   localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES);

   memctl_state_e    state_q, state_d;
   grant_e           gnt_q, gnt_d, last_q, last_d;
   logic             we_q, we_d;
   logic [1:0]       size_q, size_d, lo_q, lo_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic             i_ack_q, i_ack_d, i_err_q, i_err_d;
   logic [31:0]      i_rdata_q, i_rdata_d;
   logic             d_ack_q, d_ack_d, d_err_q, d_err_d;
   logic [31:0]      d_rdata_q, d_rdata_d;
   logic             mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

   logic             pick_d, finish, fin_err, timed_out;
   logic [31:0]      req_addr;
   logic [TMO_W-1:0] tmo_inc;
   logic [31:0]      extract_data, insert_data;

   limn2600_lane_merge u_lane_merge (
      .word         (mem_rdata),
      .wdata        (wdata_q),
      .addr_lo      (lo_q),
      .size         (size_q),
      .extract_data (extract_data),
      .insert_data  (insert_data)
   );

   // Outputs are registered, so each is computed for the state being entered.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      we_d        = we_q;
      size_d      = size_q;
      lo_d        = lo_q;
      wdata_d     = wdata_q;
      tmo_d       = tmo_q;
      mem_cs_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ack_d     = 1'b0;
      i_err_d     = 1'b0;
      i_rdata_d   = '0;
      d_ack_d     = 1'b0;
      d_err_d     = 1'b0;
      d_rdata_d   = '0;
      pick_d      = d_req && (!i_req || last_q == GNT_I);
      req_addr    = pick_d ? d_addr : i_addr;
      finish      = 1'b0;
      fin_err     = 1'b0;
      tmo_inc     = tmo_q + TMO_W'(1);
      timed_out   = (tmo_inc == TMO_LAST);

      case (state_q)
         ST_IDLE: begin
            if (i_req || d_req) begin
               gnt_d      = pick_d ? GNT_D : GNT_I;
               we_d       = pick_d ? d_we : 1'b0;
               size_d     = pick_d ? d_size : SIZE_WORD;
               wdata_d    = d_wdata;
               lo_d       = req_addr[1:0];
               tmo_d      = '0;
               mem_addr_d = {req_addr[31:2], 2'b00};
               if (!is_aligned(size_d, lo_d)) begin
                  finish  = 1'b1;
                  fin_err = 1'b1;
               end else if (!we_d) begin
                  state_d  = ST_RD_ISSUE;
                  mem_cs_d = 1'b1;
                  mem_we_d = 1'b0;
               end else if (size_d == SIZE_WORD) begin
                  state_d     = ST_WR_ISSUE;
                  mem_cs_d    = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = d_wdata;
               end else begin
                  state_d  = ST_RMW_RD_ISSUE;
                  mem_cs_d = 1'b1;
                  mem_we_d = 1'b0;
               end
            end
         end
         ST_RD_ISSUE: begin
            state_d = ST_RD_WAIT;
            tmo_d   = '0;
         end
         ST_WR_ISSUE: begin
            state_d = ST_WR_WAIT;
            tmo_d   = '0;
         end
         ST_RMW_RD_ISSUE: begin
            state_d = ST_RMW_RD_WAIT;
            tmo_d   = '0;
         end
         ST_RMW_WR_ISSUE: begin
            state_d = ST_RMW_WR_WAIT;
            tmo_d   = '0;
         end
         ST_RD_WAIT, ST_WR_WAIT, ST_RMW_WR_WAIT: begin
            if (mem_rdy) begin
               finish = 1'b1;
            end else begin
               tmo_d = tmo_inc;
               if (timed_out) begin
                  finish  = 1'b1;
                  fin_err = 1'b1;
               end
            end
         end
         ST_RMW_RD_WAIT: begin
            if (mem_rdy) begin
               state_d     = ST_RMW_WR_ISSUE;
               mem_cs_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_wdata_d = insert_data;
            end else begin
               tmo_d = tmo_inc;
               if (timed_out) begin
                  finish  = 1'b1;
                  fin_err = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            last_d  = gnt_q;
         end
         default: state_d = ST_IDLE;
      endcase

      // Stores and failed accesses return zero data.
      if (finish) begin
         state_d = ST_DONE;
         if (gnt_d == GNT_I) begin
            i_ack_d   = 1'b1;
            i_err_d   = fin_err;
            i_rdata_d = fin_err ? '0 : mem_rdata;
         end else begin
            d_ack_d   = 1'b1;
            d_err_d   = fin_err;
            d_rdata_d = (fin_err || we_d) ? '0 : extract_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= GNT_I;
         last_q      <= GNT_I;
         we_q        <= 1'b0;
         size_q      <= '0;
         lo_q        <= '0;
         wdata_q     <= '0;
         tmo_q       <= '0;
         i_ack_q     <= 1'b0;
         i_err_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         we_q        <= we_d;
         size_q      <= size_d;
         lo_q        <= lo_d;
         wdata_q     <= wdata_d;
         tmo_q       <= tmo_d;
         i_ack_q     <= i_ack_d;
         i_err_q     <= i_err_d;
         i_rdata_q   <= i_rdata_d;
         d_ack_q     <= d_ack_d;
         d_err_q     <= d_err_d;
         d_rdata_q   <= d_rdata_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign i_ack     = i_ack_q;
   assign i_err     = i_err_q;
   assign i_rdata   = i_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
